host_job_initiator: RTL and testbench

- Host-side initiator for the matrix-multiplier coprocessor's shared-memory job protocol.
- Streams operand words into shared memory through the memory arbiter (request/grant), clears the status word, then writes the config word to launch the job.
- Polls the status word until the main controller sets the done bit, latches the final status, and reports completion.
- Sits beside the processor units as one more arbiter requester; the counterpart of the main controller's config-read / status-write path.

---
 rtl/host_job_initiator_pkg.sv | 25 ++
 rtl/host_poll_timer.sv | 70 +++++++
 rtl/host_job_initiator.sv | 173 +++++++++++++++++
 tb/tb_host_job_initiator.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/host_job_initiator_pkg.sv
// Shared constants for the host job initiator: FSM state encoding, default widths and the
// shared-memory job protocol addresses/bits agreed with the main controller.
package host_job_initiator_pkg;

   localparam int unsigned DEFAULT_WORD_SIZE         = 32;
   localparam int unsigned DEFAULT_ADDRESS_WIDTH     = 10;
   localparam int unsigned DEFAULT_CONFIG_ADDRESS    = 0;
   localparam int unsigned DEFAULT_STATUS_ADDRESS    = 1;
   localparam int unsigned DEFAULT_DATA_BASE_ADDRESS = 2;
   localparam int unsigned DEFAULT_STATUS_DONE_BIT   = 0;

   localparam logic [2:0] StIdle        = 3'd0;
   localparam logic [2:0] StLoad        = 3'd1;
   localparam logic [2:0] StClearStatus = 3'd2;
   localparam logic [2:0] StWriteConfig = 3'd3;
   localparam logic [2:0] StPollWait    = 3'd4;
   localparam logic [2:0] StPollRead    = 3'd5;
   localparam logic [2:0] StPollCapture = 3'd6;
   localparam logic [2:0] StDone        = 3'd7;

   function automatic logic is_polling(input logic [2:0] state);
      return (state == StPollWait) || (state == StPollRead) || (state == StPollCapture);
   endfunction

endpackage

// File: rtl/host_poll_timer.sv
// Poll interval and poll timeout down-counters. The timeout counter exists only when
// HOST_POLL_TIMEOUT_EN is defined; otherwise it never expires.
module host_poll_timer #(
   parameter int unsigned POLL_INTERVAL  = 16,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic clk,
   input  logic reset,
   input  logic i_Interval_Load,
   input  logic i_Interval_Run,
   output logic o_Interval_Expire,
   input  logic i_Timeout_Load,
   input  logic i_Timeout_Run,
   output logic o_Timeout_Expire
);

   localparam int unsigned IntervalWidth = $clog2(POLL_INTERVAL + 1);

   logic [IntervalWidth-1:0] interval_q, interval_d;

   // Loaded with N-1 so the wait lasts exactly N running cycles.
   always_comb begin
      interval_d = interval_q;
      if (i_Interval_Load) begin
         interval_d = IntervalWidth'(POLL_INTERVAL - 1);
      end else if (i_Interval_Run && (interval_q != '0)) begin
         interval_d = interval_q - 1'b1;
      end
   end

   assign o_Interval_Expire = i_Interval_Run && (interval_q == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         interval_q <= '0;
      end else begin
         interval_q <= interval_d;
      end
   end

`ifdef HOST_POLL_TIMEOUT_EN
   localparam int unsigned TimeoutWidth = $clog2(TIMEOUT_CYCLES + 1);

   logic [TimeoutWidth-1:0] timeout_q, timeout_d;

   always_comb begin
      timeout_d = timeout_q;
      if (i_Timeout_Load) begin
         timeout_d = TimeoutWidth'(TIMEOUT_CYCLES - 1);
      end else if (i_Timeout_Run && (timeout_q != '0)) begin
         timeout_d = timeout_q - 1'b1;
      end
   end

   assign o_Timeout_Expire = i_Timeout_Run && (timeout_q == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         timeout_q <= '0;
      end else begin
         timeout_q <= timeout_d;
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout   = i_Timeout_Load ^ i_Timeout_Run ^ (TIMEOUT_CYCLES == 0);
   assign o_Timeout_Expire = 1'b0;
`endif

endmodule

// File: rtl/host_job_initiator.sv
// Host job initiator: streams operands to shared memory, clears status, writes config to launch,
// then polls status until done. HOST_POLL_TIMEOUT_EN enables a bounded poll budget.
module host_job_initiator
   import host_job_initiator_pkg::*;
#(
   parameter int unsigned WORD_SIZE         = DEFAULT_WORD_SIZE,
   parameter int unsigned ADDRESS_WIDTH     = DEFAULT_ADDRESS_WIDTH,
   parameter int unsigned CONFIG_ADDRESS    = DEFAULT_CONFIG_ADDRESS,
   parameter int unsigned STATUS_ADDRESS    = DEFAULT_STATUS_ADDRESS,
   parameter int unsigned DATA_BASE_ADDRESS = DEFAULT_DATA_BASE_ADDRESS,
   parameter int unsigned STATUS_DONE_BIT   = DEFAULT_STATUS_DONE_BIT,
   parameter int unsigned POLL_INTERVAL     = 16,
   parameter int unsigned TIMEOUT_CYCLES    = 65535
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_Start,
   input  logic [WORD_SIZE-1:0]     i_Config,
   input  logic [ADDRESS_WIDTH-1:0] i_Word_Count,
   input  logic                     i_Load_Valid,
   input  logic [WORD_SIZE-1:0]     i_Load_Data,
   output logic                     o_Load_Ready,
   output logic                     o_Request,
   input  logic                     i_Grant,
   output logic [ADDRESS_WIDTH-1:0] o_Memory_Address,
   output logic [WORD_SIZE-1:0]     o_Memory_Write_Data,
   output logic                     o_Memory_Write_Enable,
   output logic                     o_Memory_Read_Enable,
   input  logic [WORD_SIZE-1:0]     i_Memory_Read_Data,
   output logic                     o_Busy,
   output logic                     o_Done,
   output logic [WORD_SIZE-1:0]     o_Status,
   output logic                     o_Timeout
);

   logic [2:0]               state_q, state_d;
   logic [WORD_SIZE-1:0]     config_q, config_d;
   logic [WORD_SIZE-1:0]     status_q, status_d;
   logic [ADDRESS_WIDTH-1:0] count_q, count_d;
   logic [ADDRESS_WIDTH-1:0] index_q, index_d;
   logic                     timeout_q, timeout_d;
   logic                     interval_load, interval_expire;
   logic                     timeout_load, timeout_expire;
   logic                     done_bit;

   assign done_bit = i_Memory_Read_Data[STATUS_DONE_BIT];

   host_poll_timer #(
      .POLL_INTERVAL  (POLL_INTERVAL),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_poll_timer (
      .clk               (clk),
      .reset             (reset),
      .i_Interval_Load   (interval_load),
      .i_Interval_Run    (state_q == StPollWait),
      .o_Interval_Expire (interval_expire),
      .i_Timeout_Load    (timeout_load),
      .i_Timeout_Run     (is_polling(state_q)),
      .o_Timeout_Expire  (timeout_expire)
   );

   always_comb begin
      state_d               = state_q;
      config_d              = config_q;
      count_d               = count_q;
      index_d               = index_q;
      status_d              = status_q;
      timeout_d             = timeout_q;
      interval_load         = 1'b0;
      timeout_load          = 1'b0;
      o_Request             = 1'b0;
      o_Load_Ready          = 1'b0;
      o_Memory_Address      = '0;
      o_Memory_Write_Data   = '0;
      o_Memory_Write_Enable = 1'b0;
      o_Memory_Read_Enable  = 1'b0;

      case (state_q)
         StIdle, StDone: begin
            if (i_Start) begin
               config_d  = i_Config;
               count_d   = i_Word_Count;
               index_d   = '0;
               timeout_d = 1'b0;
               state_d   = (i_Word_Count != '0) ? StLoad : StClearStatus;
            end
         end
         StLoad: begin
            o_Request    = 1'b1;
            o_Load_Ready = i_Grant;
            if (i_Grant) begin
               o_Memory_Address = ADDRESS_WIDTH'(DATA_BASE_ADDRESS) + index_q;
               if (i_Load_Valid) begin
                  o_Memory_Write_Enable = 1'b1;
                  o_Memory_Write_Data   = i_Load_Data;
                  index_d               = index_q + 1'b1;
                  if (index_q == count_q - 1'b1) state_d = StClearStatus;
               end
            end
         end
         StClearStatus: begin
            o_Request = 1'b1;
            if (i_Grant) begin
               o_Memory_Address      = ADDRESS_WIDTH'(STATUS_ADDRESS);
               o_Memory_Write_Enable = 1'b1;
               state_d               = StWriteConfig;
            end
         end
         StWriteConfig: begin
            o_Request = 1'b1;
            if (i_Grant) begin
               o_Memory_Address      = ADDRESS_WIDTH'(CONFIG_ADDRESS);
               o_Memory_Write_Data   = config_q;
               o_Memory_Write_Enable = 1'b1;
               interval_load         = 1'b1;
               timeout_load          = 1'b1;
               state_d               = StPollWait;
            end
         end
         StPollWait: begin
            if (interval_expire) state_d = StPollRead;
         end
         StPollRead: begin
            o_Request = 1'b1;
            if (i_Grant) begin
               o_Memory_Address     = ADDRESS_WIDTH'(STATUS_ADDRESS);
               o_Memory_Read_Enable = 1'b1;
               state_d              = StPollCapture;
            end
         end
         StPollCapture: begin
            status_d = i_Memory_Read_Data;
            if (done_bit) begin
               state_d = StDone;
            end else begin
               interval_load = 1'b1;
               state_d       = StPollWait;
            end
         end
         default: state_d = StIdle;
      endcase

      // A done status captured in the same cycle takes precedence over the budget.
      if (is_polling(state_q) && timeout_expire && !(state_q == StPollCapture && done_bit)) begin
         state_d   = StDone;
         timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         config_q  <= '0;
         status_q  <= '0;
         count_q   <= '0;
         index_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         config_q  <= config_d;
         status_q  <= status_d;
         count_q   <= count_d;
         index_q   <= index_d;
         timeout_q <= timeout_d;
      end
   end

   assign o_Busy    = (state_q != StIdle) && (state_q != StDone);
   assign o_Done    = (state_q == StDone);
   assign o_Status  = status_q;
   assign o_Timeout = timeout_q;

endmodule

// File: tb/tb_host_job_initiator.sv
// Scoreboard bench for host_job_initiator: expected memory writes are queued as jobs are
// started and matched against the write strobes; a memory model answers status polls.
module tb_host_job_initiator;

   localparam int unsigned PI    = 4;
   localparam int unsigned TO    = 100;
   localparam int          NEVER = 1 << 30;

   typedef struct packed {
      logic [9:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_Start;
   logic [31:0] i_Config;
   logic [9:0]  i_Word_Count;
   logic        i_Load_Valid;
   logic [31:0] i_Load_Data;
   logic        o_Load_Ready;
   logic        o_Request;
   logic        i_Grant;
   logic [9:0]  o_Memory_Address;
   logic [31:0] o_Memory_Write_Data;
   logic        o_Memory_Write_Enable;
   logic        o_Memory_Read_Enable;
   logic [31:0] i_Memory_Read_Data;
   logic        o_Busy;
   logic        o_Done;
   logic [31:0] o_Status;
   logic        o_Timeout;

   int          vec_count   = 0;
   int          miscompares = 0;
   int          cyc         = 0;
   int          poll_cnt    = 0;
   int          done_after  = NEVER;
   int          idle_run    = 0;
   wr_t         exp_q[$];
   int          wr_cyc[$];
   wr_t         e;
   logic [31:0] mem [1024];
   logic [31:0] words [4];

   always #5 clk = ~clk;

   host_job_initiator #(
      .POLL_INTERVAL  (PI),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk                   (clk),
      .reset                 (reset),
      .i_Start               (i_Start),
      .i_Config              (i_Config),
      .i_Word_Count          (i_Word_Count),
      .i_Load_Valid          (i_Load_Valid),
      .i_Load_Data           (i_Load_Data),
      .o_Load_Ready          (o_Load_Ready),
      .o_Request             (o_Request),
      .i_Grant               (i_Grant),
      .o_Memory_Address      (o_Memory_Address),
      .o_Memory_Write_Data   (o_Memory_Write_Data),
      .o_Memory_Write_Enable (o_Memory_Write_Enable),
      .o_Memory_Read_Enable  (o_Memory_Read_Enable),
      .i_Memory_Read_Data    (i_Memory_Read_Data),
      .o_Busy                (o_Busy),
      .o_Done                (o_Done),
      .o_Status              (o_Status),
      .o_Timeout             (o_Timeout)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vec_count++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Shared memory; the main controller is modelled by returning done on the Nth poll.
   always @(posedge clk) begin
      if (reset || i_Start) poll_cnt <= 0;
      else if (o_Memory_Read_Enable) poll_cnt <= poll_cnt + 1;
      if (o_Memory_Write_Enable) mem[o_Memory_Address] <= o_Memory_Write_Data;
      if (o_Memory_Read_Enable)
         i_Memory_Read_Data <= (o_Memory_Address == 10'd1 && poll_cnt + 1 >= done_after) ?
                               32'h0000_0001 : mem[o_Memory_Address];
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (o_Memory_Write_Enable) begin
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               check("wr_pending", exp_q.size(), 1);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", o_Memory_Address, e.addr);
               check("wr_data", o_Memory_Write_Data, e.data);
            end
         end
         if (o_Memory_Write_Enable || o_Memory_Read_Enable)
            check("strobe_excl", o_Memory_Write_Enable & o_Memory_Read_Enable, 0);
         if (!i_Grant)
            check("nogrant_quiet", {o_Memory_Write_Enable, o_Memory_Read_Enable, o_Load_Ready}, 0);
         if (o_Memory_Read_Enable) begin
            check("rd_addr", o_Memory_Address, 1);
            check("poll_gap", idle_run >= PI, 1);
         end
         if (o_Request) idle_run = 0;
         else idle_run++;
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input logic [31:0] cfg, input int n);
      i_Start      = 1'b1;
      i_Config     = cfg;
      i_Word_Count = 10'(n);
      for (int i = 0; i < n; i++) exp_q.push_back({10'(2 + i), words[i]});
      exp_q.push_back({10'd1, 32'd0});
      exp_q.push_back({10'd0, cfg});
      wr_cyc.delete();
      next_cycle();
      i_Start = 1'b0;
   endtask

   // Streams words[0..stop-1]; grant is dropped for stall_len cycles once stall_at words are in.
   task automatic load_stream(input int stall_at, input int stall_len, input int stop);
      int k = 0;
      int stalled = 0;
      int guard = 0;
      while (k < stop && guard < 200) begin
         i_Load_Valid = 1'b1;
         i_Load_Data  = words[k];
         if (k == stall_at && stalled < stall_len) begin
            i_Grant = 1'b0;
            @(negedge clk);
            check("stall_ready", o_Load_Ready, 0);
            check("stall_req", o_Request, 1);
            stalled++;
         end else begin
            i_Grant = 1'b1;
            @(negedge clk);
            if (o_Load_Ready) k++;
         end
         guard++;
         next_cycle();
      end
      check("load_accepted", k, stop);
      i_Grant      = 1'b1;
      i_Load_Valid = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (exp_q.size() != 0 && n < 100);
      check(tag, exp_q.size(), 0);
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!o_Done && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check(tag, o_Done, 1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_req"}, o_Request, 0);
      check({tag, "_ready"}, o_Load_Ready, 0);
      check({tag, "_strobes"}, {o_Memory_Write_Enable, o_Memory_Read_Enable}, 0);
      check({tag, "_addr"}, o_Memory_Address, 0);
      check({tag, "_wdata"}, o_Memory_Write_Data, 0);
      check({tag, "_busy_done"}, {o_Busy, o_Done}, 0);
      check({tag, "_status"}, o_Status, 0);
      check({tag, "_timeout"}, o_Timeout, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset        = 1'b1;
      i_Start      = 1'b0;
      i_Config     = '0;
      i_Word_Count = '0;
      i_Load_Valid = 1'b0;
      i_Load_Data  = '0;
      i_Grant      = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("reset");
      next_cycle();
      reset = 1'b0;
      next_cycle();

      // Job 1: four words with continuous grant, done on the third poll.
      words = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
      done_after = 3;
      start_job(32'h0000_0203, 4);
      load_stream(99, 0, 4);
      wait_drain("j1_drain");
      check("j1_wr_count", wr_cyc.size(), 6);
      if (wr_cyc.size() == 6) check("j1_wr_span", wr_cyc[5] - wr_cyc[0], 5);
      wait_done("j1_done");
      check("j1_busy", o_Busy, 0);
      check("j1_status", o_Status, 32'h1);
      check("j1_polls", poll_cnt, 3);
      check("j1_timeout", o_Timeout, 0);
      check("j1_mem_cfg", mem[0], 32'h0000_0203);
      check("j1_mem_w3", mem[4], 32'hA3);

      // Job 2: grant withdrawn for 3 cycles after word 2; a start while busy is ignored.
      next_cycle();
      words = '{32'hB1, 32'hB2, 32'hB3, 32'hB4};
      done_after = 2;
      start_job(32'h0000_0311, 4);
      load_stream(2, 3, 4);
      wait_drain("j2_drain");
      next_cycle();
      i_Start      = 1'b1;
      i_Config     = 32'hDEAD_BEEF;
      i_Word_Count = 10'd1;
      next_cycle();
      i_Start = 1'b0;
      @(negedge clk);
      check("j2_busy_hold", o_Busy, 1);
      wait_done("j2_done");
      check("j2_status", o_Status, 32'h1);
      check("j2_mem_cfg", mem[0], 32'h0000_0311);
      check("j2_mem_w4", mem[5], 32'hB4);

      // Job 3: zero words goes straight to status clear and config launch.
      next_cycle();
      done_after = 2;
      start_job(32'h0000_0105, 0);
      @(negedge clk);
      check("j3_done_cleared", o_Done, 0);
      check("j3_busy", o_Busy, 1);
      wait_drain("j3_drain");
      wait_done("j3_done");
      check("j3_mem_cfg", mem[0], 32'h0000_0105);
      check("j3_status", o_Status, 32'h1);

      // Job 4: reset after two words aborts; a fresh job reloads from the base address.
      next_cycle();
      words = '{32'hC1, 32'hC2, 32'hC3, 32'hC4};
      start_job(32'h0000_0404, 4);
      load_stream(99, 0, 2);
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      check_idle_outputs("midreset");
      next_cycle();
      reset = 1'b0;
      next_cycle();
      words = '{32'hD1, 32'hD2, 32'h0, 32'h0};
      done_after = 1;
      start_job(32'h0000_0502, 2);
      load_stream(99, 0, 2);
      wait_drain("j4_drain");
      if (wr_cyc.size() > 0) check("j4_first_wr", wr_cyc.size(), 4);
      wait_done("j4_done");
      check("j4_mem_w1", mem[2], 32'hD1);
      check("j4_status", o_Status, 32'h1);

`ifdef HOST_POLL_TIMEOUT_EN
      // Status never completes: the poll budget must end the job with a timeout.
      next_cycle();
      begin
         int t0;
         done_after = NEVER;
         t0 = cyc;
         start_job(32'h0000_0077, 0);
         wait_drain("to_drain");
         wait_done("to_done");
         check("to_flag", o_Timeout, 1);
         check("to_status", o_Status, 32'h0);
         check("to_min_cycles", (cyc - t0) >= TO, 1);
      end
      next_cycle();
      done_after = 1;
      start_job(32'h0000_0078, 0);
      @(negedge clk);
      check("to_clear_flag", o_Timeout, 0);
      check("to_clear_done", o_Done, 0);
      wait_drain("to2_drain");
      wait_done("to2_done");
      check("to2_flag", o_Timeout, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule
